// File: rtl/parc_dmem_responder.sv
// rtl/parc_dmem_responder.sv - PARCv2 memory responder: word storage, subword access, fixed latency
// Responses flow through a LATENCY-deep delay line into an in-order queue whose head drives the outputs.
module parc_dmem_responder #(
   parameter int NUM_WORDS   = 256,
   parameter int LATENCY     = 1,
   parameter int QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        memreq_val,
   output logic        memreq_rdy,
   input  logic        memreq_msg_type,
   input  logic [31:0] memreq_msg_addr,
   input  logic [1:0]  memreq_msg_len,
   input  logic [31:0] memreq_msg_data,
   output logic        memresp_val,
   input  logic        memresp_rdy,
   output logic        memresp_msg_type,
   output logic [1:0]  memresp_msg_len,
   output logic [31:0] memresp_msg_data,
   output logic        memresp_msg_err
);
   localparam int AW = $clog2(NUM_WORDS);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   typedef struct packed {
      logic        typ;
      logic [1:0]  len;
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic [31:0]   mem_q [NUM_WORDS];

   logic          req_fire;
   logic          resp_fire;
   logic [AW-1:0] widx;
   logic [1:0]    off;
   logic [2:0]    nbytes;
   logic [3:0]    lane_mask;
   logic [3:0]    be;
   logic [31:0]   byte_mask;
   logic [31:0]   rd_word;
   logic [31:0]   wr_shift;
   logic          acc_err;
   resp_t         in_pay;

   logic          enq_vld;
   resp_t         enq_pay;

   resp_t         q_pay_q [QUEUE_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] q_cnt_q, q_cnt_d;
   logic [CW-1:0] inflight_q, inflight_d;
   resp_t         head;

   assign req_fire  = memreq_val && memreq_rdy;
   assign resp_fire = memresp_val && memresp_rdy;

   assign widx = memreq_msg_addr[AW+1:2];
   assign off  = memreq_msg_addr[1:0];

   always_comb begin
      nbytes    = 3'd4;
      lane_mask = 4'b1111;
      byte_mask = 32'hFFFF_FFFF;
      case (memreq_msg_len)
         2'd1: begin nbytes = 3'd1; lane_mask = 4'b0001; byte_mask = 32'h0000_00FF; end
         2'd2: begin nbytes = 3'd2; lane_mask = 4'b0011; byte_mask = 32'h0000_FFFF; end
         2'd3: begin nbytes = 3'd3; lane_mask = 4'b0111; byte_mask = 32'h00FF_FFFF; end
         default: ;
      endcase
   end

   // Power-of-two depth: any set address bit above the index field is out of range.
   assign acc_err  = (|memreq_msg_addr[31:AW+2]) || (({1'b0, off} + nbytes) > 3'd4);
   assign be       = lane_mask << off;
   assign rd_word  = mem_q[widx];
   assign wr_shift = memreq_msg_data << {off, 3'b000};

   always_comb begin
      in_pay      = '0;
      in_pay.typ  = memreq_msg_type;
      in_pay.len  = memreq_msg_len;
      in_pay.err  = acc_err;
      if (!memreq_msg_type && !acc_err)
         in_pay.data = (rd_word >> {off, 3'b000}) & byte_mask;
   end

   always_ff @(posedge clk) begin
      if (req_fire && memreq_msg_type && !acc_err)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[widx][8*b +: 8] <= wr_shift[8*b +: 8];
   end

   // The acceptance edge counts as the first latency cycle, so L-1 register stages follow it.
   generate
      if (LATENCY == 1) begin : g_no_delay
         assign enq_vld = req_fire;
         assign enq_pay = in_pay;
      end else begin : g_delay
         logic [LATENCY-2:0] dl_vld_q;
         resp_t              dl_pay_q [LATENCY-1];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               dl_vld_q <= '0;
            end else begin
               dl_vld_q[0] <= req_fire;
               for (int i = 1; i < LATENCY - 1; i++) dl_vld_q[i] <= dl_vld_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            dl_pay_q[0] <= in_pay;
            for (int i = 1; i < LATENCY - 1; i++) dl_pay_q[i] <= dl_pay_q[i-1];
         end

         assign enq_vld = dl_vld_q[LATENCY-2];
         assign enq_pay = dl_pay_q[LATENCY-2];
      end
   endgenerate

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      q_cnt_d    = q_cnt_q;
      inflight_d = inflight_q;
      if (enq_vld)   wr_ptr_d = ptr_next(wr_ptr_q);
      if (resp_fire) rd_ptr_d = ptr_next(rd_ptr_q);
      case ({enq_vld, resp_fire})
         2'b10:   q_cnt_d = q_cnt_q + CW'(1);
         2'b01:   q_cnt_d = q_cnt_q - CW'(1);
         default: ;
      endcase
      case ({req_fire, resp_fire})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         q_cnt_q    <= '0;
         inflight_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         q_cnt_q    <= q_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_vld) q_pay_q[wr_ptr_q] <= enq_pay;
   end

   // The inflight credit covers both the delay line and the queue, so a full queue never sees an arrival.
   assert property (@(posedge clk) disable iff (!reset_n)
      !(enq_vld && (q_cnt_q == CW'(QUEUE_DEPTH)) && !resp_fire));

   assign memreq_rdy  = (inflight_q < CW'(QUEUE_DEPTH)) && reset_n;
   assign memresp_val = (q_cnt_q != '0);
   assign head        = memresp_val ? q_pay_q[rd_ptr_q] : '0;

   assign memresp_msg_type = head.typ;
   assign memresp_msg_len  = head.len;
   assign memresp_msg_data = head.data;
   assign memresp_msg_err  = head.err;
endmodule

// File: tb/tb_parc_dmem_responder.sv
// tb/tb_parc_dmem_responder.sv - directed and randomized checks of parc_dmem_responder
// A byte-array memory model and expected-response queue predict every response.
module tb_parc_dmem_responder;
   localparam int NUM_WORDS   = 256;
   localparam int LATENCY     = 1;
   localparam int QUEUE_DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        memreq_val = 1'b0;
   logic        memreq_rdy;
   logic        memreq_msg_type = 1'b0;
   logic [31:0] memreq_msg_addr = '0;
   logic [1:0]  memreq_msg_len = '0;
   logic [31:0] memreq_msg_data = '0;
   logic        memresp_val;
   logic        memresp_rdy = 1'b1;
   logic        memresp_msg_type;
   logic [1:0]  memresp_msg_len;
   logic [31:0] memresp_msg_data;
   logic        memresp_msg_err;

   parc_dmem_responder #(
      .NUM_WORDS  (NUM_WORDS),
      .LATENCY    (LATENCY),
      .QUEUE_DEPTH(QUEUE_DEPTH)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .memreq_val      (memreq_val),
      .memreq_rdy      (memreq_rdy),
      .memreq_msg_type (memreq_msg_type),
      .memreq_msg_addr (memreq_msg_addr),
      .memreq_msg_len  (memreq_msg_len),
      .memreq_msg_data (memreq_msg_data),
      .memresp_val     (memresp_val),
      .memresp_rdy     (memresp_rdy),
      .memresp_msg_type(memresp_msg_type),
      .memresp_msg_len (memresp_msg_len),
      .memresp_msg_data(memresp_msg_data),
      .memresp_msg_err (memresp_msg_err)
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_total = 0;
   logic [7:0]  ref_mem [NUM_WORDS*4];
   logic [35:0] sb [$];
   logic        req_fired = 1'b0;
   logic [35:0] resp_bits;
   int          accepts;

   assign resp_bits = {memresp_msg_type, memresp_msg_len, memresp_msg_err, memresp_msg_data};

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Response = {type, len, err, data}; updates the model memory for legal writes.
   function automatic logic [35:0] model(input logic t, input logic [31:0] a,
                                         input logic [1:0] l, input logic [31:0] d);
      int          nb;
      int          offs;
      logic        err;
      logic [31:0] r;
      nb   = (l == 2'd0) ? 4 : int'(l);
      offs = int'(a[1:0]);
      r    = '0;
      err  = (a[31:2] >= NUM_WORDS) || (offs + nb > 4);
      if (!err)
         for (int k = 0; k < nb; k++)
            if (t) ref_mem[a + k] = d[8*k +: 8];
            else   r[8*k +: 8]    = ref_mem[a + k];
      return {t, l, err, r};
   endfunction

   task automatic tick();
      logic [35:0] exp;
      req_fired = memreq_val && memreq_rdy;
      if (memresp_val && memresp_rdy) begin
         if (sb.size() == 0) begin
            n_total++;
            $error("FAIL unexpected_resp: observed %h expected no response", resp_bits);
         end else begin
            exp = sb.pop_front();
            check("resp", resp_bits, exp);
         end
      end
      if (req_fired)
         sb.push_back(model(memreq_msg_type, memreq_msg_addr, memreq_msg_len, memreq_msg_data));
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic t, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
      memreq_val      = 1'b1;
      memreq_msg_type = t;
      memreq_msg_addr = a;
      memreq_msg_len  = l;
      memreq_msg_data = d;
   endtask

   task automatic send(input logic t, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
      logic done;
      done = 1'b0;
      set_req(t, a, l, d);
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         done = req_fired;
      end
      if (!done) begin
         n_total++;
         $error("FAIL send_timeout: observed no acceptance expected acceptance of addr %h", a);
      end
   endtask

   task automatic drain();
      memreq_val  = 1'b0;
      memresp_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0 && !memresp_val) break;
         tick();
      end
      check("drain_empty", 36'(sb.size()), 36'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      // reset then idle
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_rdy", memreq_rdy, 0);
      check("rst_resp_val", memresp_val, 0);
      check("rst_resp_fields", resp_bits, 0);
      reset_n = 1'b1;
      tick();
      check("post_rst_req_rdy", memreq_rdy, 1);

      // word write then read on the next edge
      send(1'b1, 32'h0, 2'd0, 32'hDEAD_BEEF);
      send(1'b0, 32'h0, 2'd0, 32'h0);
      memreq_val = 1'b0;
      check("word_rd_val", memresp_val, 1);
      check("word_rd_data", memresp_msg_data, 32'hDEAD_BEEF);
      check("word_rd_err", memresp_msg_err, 0);
      drain();

      // subword writes onto a zero word
      send(1'b1, 32'h0, 2'd0, 32'h0);
      send(1'b1, 32'h1, 2'd1, 32'h0000_00AB);
      send(1'b1, 32'h2, 2'd2, 32'h0000_1234);
      drain();
      set_req(1'b0, 32'h0, 2'd0, 32'h0);
      check("no_flow_through", memresp_val, 0);
      send(1'b0, 32'h0, 2'd0, 32'h0);
      memreq_val = 1'b0;
      check("sub_word_val", memresp_val, 1);
      check("sub_word_data", memresp_msg_data, 32'h1234_AB00);
      drain();
      send(1'b0, 32'h1, 2'd1, 32'h0);
      memreq_val = 1'b0;
      check("sub_byte_data", memresp_msg_data, 32'h0000_00AB);
      drain();

      // error cases
      send(1'b0, 32'h400, 2'd0, 32'h0);
      memreq_val = 1'b0;
      check("err_oor_err", memresp_msg_err, 1);
      check("err_oor_data", memresp_msg_data, 0);
      drain();
      send(1'b1, 32'h3, 2'd2, 32'h0000_FFFF);
      memreq_val = 1'b0;
      check("err_misalign_err", memresp_msg_err, 1);
      drain();
      send(1'b0, 32'h0, 2'd0, 32'h0);
      memreq_val = 1'b0;
      check("err_word_unchanged", memresp_msg_data, 32'h1234_AB00);
      drain();

      // backpressure: responses held, requests offered every cycle
      memresp_rdy = 1'b0;
      accepts = 0;
      for (int i = 0; i < 5; i++) begin
         set_req(1'b0, 32'(i), 2'd1, 32'h0);
         if (memreq_rdy) accepts++;
         tick();
      end
      memreq_val = 1'b0;
      check("bp_accepts", 36'(accepts), 36'(QUEUE_DEPTH));
      check("bp_req_rdy_low", memreq_rdy, 0);
      check("bp_hold_data", resp_bits, sb[0]);
      tick();
      check("bp_hold_data2", resp_bits, sb[0]);
      memresp_rdy = 1'b1;
      check("bp_rdy_before_deq", memreq_rdy, 0);
      tick();
      check("bp_rdy_reassert", memreq_rdy, 1);
      drain();

      // streaming with simultaneous enqueue and dequeue
      for (int i = 0; i < 6; i++) begin
         set_req(1'b0, 32'(i % 4), 2'd1, 32'h0);
         tick();
         check("stream_req_rdy", memreq_rdy, 1);
         check("stream_resp_val", memresp_val, 1);
      end
      drain();

      // reset with two responses queued
      send(1'b1, 32'h8, 2'd0, 32'hCAFE_F00D);
      drain();
      memresp_rdy = 1'b0;
      send(1'b0, 32'h0, 2'd0, 32'h0);
      send(1'b0, 32'h8, 2'd0, 32'h0);
      memreq_val = 1'b0;
      check("mid_queued_val", memresp_val, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_val", memresp_val, 0);
      check("mid_rst_req_rdy", memreq_rdy, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      memresp_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("no_stale_resp", memresp_val, 0);
         tick();
      end
      send(1'b0, 32'h8, 2'd0, 32'h0);
      memreq_val = 1'b0;
      check("persist_data", memresp_msg_data, 32'hCAFE_F00D);
      drain();

      // randomized traffic against the model
      for (int w = 0; w < 16; w++) send(1'b1, 32'(4 * w), 2'd0, $urandom);
      drain();
      memreq_val = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!memreq_val || req_fired) begin
            memreq_val      = ($urandom_range(0, 3) != 0);
            memreq_msg_type = 1'($urandom_range(0, 1));
            memreq_msg_len  = 2'($urandom_range(0, 3));
            memreq_msg_data = $urandom;
            case ($urandom_range(0, 9))
               0:       memreq_msg_addr = 32'h400 + 32'($urandom_range(0, 255));
               1:       memreq_msg_addr = {1'b1, 31'($urandom)};
               default: memreq_msg_addr = 32'($urandom_range(0, 63));
            endcase
         end
         memresp_rdy = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
